// File: rtl/mux_share_arbiter.sv
// Two-requester round-robin arbiter driving the select of a shared 2:1 data mux.
// Optional ARB_TIMEOUT_EN adds a hold counter that forces hand-over after HOLD_LIMIT cycles.
module mux_share_arbiter #(
   parameter int unsigned WIDTH      = 32,
   parameter int unsigned HOLD_LIMIT = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             Req_0,
   input  logic             Req_1,
   input  logic [WIDTH-1:0] Input_0,
   input  logic [WIDTH-1:0] Input_1,
   output logic             Gnt_0,
   output logic             Gnt_1,
   output logic             Sel,
   output logic [WIDTH-1:0] Output,
   output logic             Out_Valid,
   output logic             Preempt
);

   typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

   state_t state, state_nxt;
   logic   last, last_nxt;
   logic   pre_nxt;

   if (HOLD_LIMIT < 1 || HOLD_LIMIT > 255) begin : g_bad_hold
      $error("HOLD_LIMIT must be within 1..255");
   end

`ifdef ARB_TIMEOUT_EN
   localparam logic [7:0] HOLD_MAX = 8'(HOLD_LIMIT - 1);
   logic [7:0] hold_cnt;
   logic       expire;

   assign expire = (hold_cnt == HOLD_MAX);
`endif

   always_comb begin
      state_nxt = state;
      last_nxt  = last;
      pre_nxt   = 1'b0;
      unique case (state)
         IDLE: begin
            // last == 1 means requester 1 was served most recently, so 0 wins a tie
            if (Req_0 && (!Req_1 || last)) state_nxt = GRANT0;
            else if (Req_1)                state_nxt = GRANT1;
         end
         GRANT0: begin
            if (!Req_0) begin
               last_nxt  = 1'b0;
               state_nxt = Req_1 ? GRANT1 : IDLE;
            end
`ifdef ARB_TIMEOUT_EN
            else if (Req_1 && expire) begin
               last_nxt  = 1'b0;
               state_nxt = GRANT1;
               pre_nxt   = 1'b1;
            end
`endif
         end
         GRANT1: begin
            if (!Req_1) begin
               last_nxt  = 1'b1;
               state_nxt = Req_0 ? GRANT0 : IDLE;
            end
`ifdef ARB_TIMEOUT_EN
            else if (Req_0 && expire) begin
               last_nxt  = 1'b1;
               state_nxt = GRANT0;
               pre_nxt   = 1'b1;
            end
`endif
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         last  <= 1'b1;
         Gnt_0 <= 1'b0;
         Gnt_1 <= 1'b0;
         Sel   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
         Preempt  <= 1'b0;
         hold_cnt <= '0;
`endif
      end else begin
         state <= state_nxt;
         last  <= last_nxt;
         Gnt_0 <= (state_nxt == GRANT0);
         Gnt_1 <= (state_nxt == GRANT1);
         // Sel keeps pointing at the previous owner while idle
         if (state_nxt != IDLE) Sel <= (state_nxt == GRANT1);
`ifdef ARB_TIMEOUT_EN
         Preempt <= pre_nxt;
         // saturating at HOLD_MAX lets a late competing request preempt on the next edge
         if (state_nxt != state)                        hold_cnt <= '0;
         else if (state != IDLE && hold_cnt != HOLD_MAX) hold_cnt <= hold_cnt + 8'd1;
`endif
      end
   end

`ifndef ARB_TIMEOUT_EN
   assign Preempt = 1'b0;
`endif

   assign Out_Valid = Gnt_0 | Gnt_1;
   assign Output    = Sel ? Input_1 : Input_0;

endmodule

// File: tb/tb_mux_share_arbiter.sv
// Directed bench for mux_share_arbiter: ownership model checked every cycle plus literal checks.
// Preemption scenario runs only when ARB_TIMEOUT_EN is defined (HOLD_LIMIT = 4).
module tb_mux_share_arbiter;
   localparam int unsigned W  = 32;
   localparam int unsigned HL = 4;

   logic         clk = 1'b0;
   logic         rst, Req_0, Req_1;
   logic [W-1:0] Input_0, Input_1, Output;
   logic         Gnt_0, Gnt_1, Sel, Out_Valid, Preempt;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   mux_share_arbiter #(.WIDTH(W), .HOLD_LIMIT(HL)) dut (
      .clk(clk), .rst(rst), .Req_0(Req_0), .Req_1(Req_1),
      .Input_0(Input_0), .Input_1(Input_1),
      .Gnt_0(Gnt_0), .Gnt_1(Gnt_1), .Sel(Sel), .Output(Output),
      .Out_Valid(Out_Valid), .Preempt(Preempt)
   );

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Model: who owns the bus (-1 none), who was served last, and how long the owner has held it
   int owner = -1;
   bit m_last = 1'b1, m_sel = 1'b0, m_pre = 1'b0;
   int held = 0;
   bit en = 1'b0;

   always @(posedge clk) begin
      automatic logic [1:0] req = {Req_1, Req_0};
      automatic int nxt = owner;
      automatic bit lst = m_last;
      automatic bit pre = 1'b0;
      if (rst) begin
         owner  <= -1;
         m_last <= 1'b1;
         m_sel  <= 1'b0;
         m_pre  <= 1'b0;
         held   <= 0;
      end else begin
         if (owner < 0) begin
            if (req == 2'b11)  nxt = lst ? 0 : 1;
            else if (req[0])   nxt = 0;
            else if (req[1])   nxt = 1;
         end else if (!req[owner]) begin
            lst = (owner == 1);
            nxt = req[1-owner] ? 1 - owner : -1;
         end
`ifdef ARB_TIMEOUT_EN
         else if (held >= HL && req[1-owner]) begin
            lst = (owner == 1);
            nxt = 1 - owner;
            pre = 1'b1;
         end
`endif
         owner  <= nxt;
         m_last <= lst;
         m_pre  <= pre;
         held   <= (nxt < 0) ? 0 : (nxt != owner) ? 1 : held + 1;
         if (nxt >= 0) m_sel <= (nxt == 1);
      end
   end

   always @(negedge clk) begin
      if (en) begin
         chk("m_gnt_0",   Gnt_0,     (owner == 0));
         chk("m_gnt_1",   Gnt_1,     (owner == 1));
         chk("m_sel",     Sel,       m_sel);
         chk("m_valid",   Out_Valid, (owner >= 0));
         chk("m_output",  Output,    m_sel ? Input_1 : Input_0);
         chk("m_preempt", Preempt,   m_pre);
      end
   end

   initial begin
      rst = 1'b1; Req_0 = 1'b0; Req_1 = 1'b0;
      Input_0 = 32'h1234_5678; Input_1 = '0;
      tick; en = 1'b1;
      tick; rst = 1'b0;
      @(negedge clk);
      chk("rst_gnt_0", Gnt_0, 0);
      chk("rst_gnt_1", Gnt_1, 0);
      chk("rst_sel", Sel, 0);
      chk("rst_valid", Out_Valid, 0);
      chk("rst_preempt", Preempt, 0);

      // single request from requester 1
      tick; Input_1 = 32'hDEAD_BEEF; Req_1 = 1'b1;
      tick; @(negedge clk);
      chk("single_gnt_1", Gnt_1, 1);
      chk("single_sel", Sel, 1);
      chk("single_out", Output, 32'hDEAD_BEEF);
      chk("single_valid", Out_Valid, 1);
      tick; Input_1 = 32'hCAFE_F00D;
      tick; Req_1 = 1'b0;
      tick; @(negedge clk);
      chk("release_gnt_1", Gnt_1, 0);
      chk("release_sel_hold", Sel, 1);
      chk("release_valid", Out_Valid, 0);

      // tie: last served was 1, so requester 0 first, then direct hand-over
      tick; Req_0 = 1'b1; Req_1 = 1'b1; Input_0 = 32'hA5A5_0001;
      tick; @(negedge clk);
      chk("tie_gnt_0", Gnt_0, 1);
      chk("tie_gnt_1", Gnt_1, 0);
      tick; Input_0 = 32'hA5A5_0002;
      tick; Req_0 = 1'b0;
      tick; @(negedge clk);
      chk("handover_gnt_1", Gnt_1, 1);
      chk("handover_gnt_0", Gnt_0, 0);
      tick; Req_1 = 1'b0;
      tick; Req_0 = 1'b1; Req_1 = 1'b1;
      tick; @(negedge clk);
      chk("rr_tie_gnt_0", Gnt_0, 1);
      tick; Req_0 = 1'b0; Req_1 = 1'b0;

      // glitch: Req_1 pulses between edges and is low when sampled
      tick; Req_1 = 1'b1; #3 Req_1 = 1'b0;
      tick; @(negedge clk);
      chk("glitch_gnt_1", Gnt_1, 0);
      chk("glitch_valid", Out_Valid, 0);

      tick; Req_0 = 1'b1;
      tick; Req_1 = 1'b1;
`ifdef ARB_TIMEOUT_EN
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("pre_gnt_0", Gnt_0, 1);
         tick;
      end
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("pre_gnt_1", Gnt_1, 1);
         chk("pre_pulse", Preempt, (k == 0));
         tick;
      end
      @(negedge clk);
      chk("pre_back_gnt_0", Gnt_0, 1);
      chk("pre_back_pulse", Preempt, 1);
`else
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         chk("lock_gnt_0", Gnt_0, 1);
         chk("lock_gnt_1", Gnt_1, 0);
         tick; Input_0 = 32'h0F00_0000 + k;
      end
`endif
      Req_0 = 1'b0;
      tick; @(negedge clk);
      chk("unlock_gnt_1", Gnt_1, 1);

      // reset while requester 1 holds the bus
      tick; rst = 1'b1;
      tick; rst = 1'b0;
      @(negedge clk);
      chk("midrst_gnt_1", Gnt_1, 0);
      chk("midrst_sel", Sel, 0);
      chk("midrst_valid", Out_Valid, 0);
      tick; @(negedge clk);
      chk("regrant_gnt_1", Gnt_1, 1);
      tick; Req_1 = 1'b0;
      tick; tick;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
